// File: rtl/multiplication_pkg.sv
// Shared binary32 constants, operand decode types and rounding helper for
// the single-precision multiplier.
package multiplication_pkg;

  // binary32 field layout
  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int FP_W   = SIGN_W + EXP_W + MAN_W;

  // Significand with hidden bit, and the full-precision product width
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;

  // Exponent arithmetic is done signed and two bits wider than the field
  // so that ea+eb-bias cannot wrap in either direction.
  localparam int EXPC_W = EXP_W + 2;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  // Decoded operand. Exponent 0 (zero or subnormal) is treated as zero.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] v);
    fp_unpacked_t u;
    u.sign    = v[FP_W-1];
    u.exp     = v[FP_W-2:MAN_W];
    u.man     = v[MAN_W-1:0];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == EXP_W'(EXP_MAX)) && (u.man == '0);
    u.is_nan  = (u.exp == EXP_W'(EXP_MAX)) && (u.man != '0);
    return u;
  endfunction

  // Round-to-nearest-even increment decision.
  function automatic logic rne_round_up(input logic lsb,
                                        input logic guard,
                                        input logic rnd,
                                        input logic sticky);
    return guard & (rnd | sticky | lsb);
  endfunction

endpackage

// File: rtl/multiplication_fp32_mul_core.sv
// Combinational binary32 multiply datapath: unpack, 24x24 significand
// multiply, normalise, round-to-nearest-even, classify and pack.
module fp32_mul_core
  import multiplication_pkg::*;
(
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic [31:0] result,
  output logic        exception,
  output logic        overflow,
  output logic        underflow
);

  localparam logic signed [EXPC_W-1:0] BIAS_S    = EXPC_W'(BIAS);
  localparam logic signed [EXPC_W-1:0] EXP_MAX_S = EXPC_W'(EXP_MAX);

  fp_unpacked_t ua;
  fp_unpacked_t ub;
  logic         res_sign;

  logic [SIG_W-1:0]  sig_a;
  logic [SIG_W-1:0]  sig_b;
  logic [PROD_W-1:0] prod;

  logic [MAN_W-1:0] mant_pre;
  logic             guard;
  logic             rnd;
  logic             sticky;
  logic             norm_inc;
  logic             round_up;
  logic [MAN_W:0]   mant_rnd;
  logic [MAN_W-1:0] mant_final;

  logic signed [EXPC_W-1:0] exp_sum;
  logic signed [EXPC_W-1:0] exp_final;

  logic any_nan;
  logic inf_times_zero;
  logic any_special;

  assign ua       = fp_unpack(a_operand);
  assign ub       = fp_unpack(b_operand);
  assign res_sign = ua.sign ^ ub.sign;

  assign sig_a = {1'b1, ua.man};
  assign sig_b = {1'b1, ub.man};
  assign prod  = sig_a * sig_b;

  // Normalise: the product of two [1,2) significands lies in [1,4); when
  // bit 47 is set the binary point moves one place and the exponent bumps.
  always_comb begin
    mant_pre = '0;
    guard    = 1'b0;
    rnd      = 1'b0;
    sticky   = 1'b0;
    norm_inc = 1'b0;
    if (prod[PROD_W-1]) begin
      mant_pre = prod[PROD_W-2:PROD_W-1-MAN_W];
      guard    = prod[PROD_W-2-MAN_W];
      rnd      = prod[PROD_W-3-MAN_W];
      sticky   = |prod[PROD_W-4-MAN_W:0];
      norm_inc = 1'b1;
    end else begin
      mant_pre = prod[PROD_W-3:PROD_W-2-MAN_W];
      guard    = prod[PROD_W-3-MAN_W];
      rnd      = prod[PROD_W-4-MAN_W];
      sticky   = |prod[PROD_W-5-MAN_W:0];
    end
  end

  // Round and renormalise. A carry out of the mantissa means the rounded
  // value became exactly 2.0 * 2^e, so the stored mantissa bits are all
  // zero and the exponent goes up by one.
  always_comb begin
    round_up   = rne_round_up(mant_pre[0], guard, rnd, sticky);
    mant_rnd   = {1'b0, mant_pre} + {{MAN_W{1'b0}}, round_up};
    mant_final = mant_rnd[MAN_W-1:0];
    exp_sum    = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp})
               - BIAS_S + $signed({{(EXPC_W-1){1'b0}}, norm_inc});
    exp_final  = exp_sum + $signed({{(EXPC_W-1){1'b0}}, mant_rnd[MAN_W]});
  end

  assign any_nan        = ua.is_nan | ub.is_nan;
  assign inf_times_zero = (ua.is_inf & ub.is_zero) | (ub.is_inf & ua.is_zero);
  assign any_special    = (ua.exp == EXP_W'(EXP_MAX)) | (ub.exp == EXP_W'(EXP_MAX));

  // Classify and pack. Priority order keeps the three flags exclusive:
  // special operands first, then zero operands, then exponent range.
  always_comb begin
    result    = '0;
    exception = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (any_special) begin
      exception = 1'b1;
      if (any_nan || inf_times_zero) begin
        result = QNAN;
      end else begin
        result = {res_sign, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
      end
    end else if (ua.is_zero || ub.is_zero) begin
      result = {res_sign, {(FP_W-1){1'b0}}};
    end else if (exp_final >= EXP_MAX_S) begin
      overflow = 1'b1;
      result   = {res_sign, EXP_W'(EXP_MAX), {MAN_W{1'b0}}};
    end else if (exp_final <= $signed(EXPC_W'(0))) begin
      underflow = 1'b1;
      result    = {res_sign, {(FP_W-1){1'b0}}};
    end else begin
      result = {res_sign, exp_final[EXP_W-1:0], mant_final};
    end
  end

endmodule

// File: rtl/multiplication.sv
// Single-precision (binary32) multiplier with one cycle of latency. The
// datapath is fully combinational in fp32_mul_core; this level only holds
// the output registers.
//
// Handshake: in_valid marks a:b as a new operation this cycle; there is no
// ready, so an operation is accepted on every edge where in_valid=1.
// out_valid is in_valid delayed one cycle and qualifies result and the
// flags; while in_valid=0 the outputs hold their last values.
module multiplication
  import multiplication_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        in_valid,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] result
);

  logic [31:0] core_result;
  logic        core_exception;
  logic        core_overflow;
  logic        core_underflow;

  fp32_mul_core u_core (
    .a_operand (a_operand),
    .b_operand (b_operand),
    .result    (core_result),
    .exception (core_exception),
    .overflow  (core_overflow),
    .underflow (core_underflow)
  );

  // Valid pipeline bit: follows in_valid one cycle later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

  // Output registers: capture only on accepted operations, hold otherwise.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (in_valid) begin
      result    <= core_result;
      Exception <= core_exception;
      Overflow  <= core_overflow;
      Underflow <= core_underflow;
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the binary32 multiplier: driver pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
module tb_multiplication;

  logic        CLK;
  logic        RESET_N;
  logic        in_valid;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic        Exception;
  logic        Overflow;
  logic        Underflow;
  logic [31:0] result;

  // {Exception, Overflow, Underflow, result}
  logic [34:0] exp_q[$];

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_res;

  multiplication dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .in_valid  (in_valid),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .result    (result)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [34:0] act,
                       input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: one operation per cycle, expectation pushed as it is issued.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic e,
                      input logic o, input logic u);
    @(posedge CLK);
    #1;
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    exp_q.push_back({e, o, u, r});
    last_res = r;
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    check("queue_drained", 35'(exp_q.size()), 35'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (RESET_N && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got result %h with empty queue", result);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        check("result_and_flags", {Exception, Overflow, Underflow, result}, e);
      end
    end
  end

  initial begin
    RESET_N   = 1'b0;
    in_valid  = 1'b0;
    a_operand = '0;
    b_operand = '0;
    last_res  = '0;
    #2;
    check("reset_state", {out_valid, Exception, Overflow, Underflow, result[30:0]}, 35'd0);
    check("reset_result_msb", {34'd0, result[31]}, 35'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    //    a              b              result         E  O  U
    send(32'h40A00000, 32'h40A00000, 32'h41C80000, 0, 0, 0); // 5*5
    send(32'h3F800000, 32'hC0000000, 32'hC0000000, 0, 0, 0); // 1*-2
    send(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0); // 2*3
    send(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0); // 1.5^2
    send(32'h7F000000, 32'h7F000000, 32'h7F800000, 0, 1, 0); // overflow
    send(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 0, 0, 0); // just below overflow
    send(32'h00800000, 32'h00800000, 32'h00000000, 0, 0, 1); // underflow
    send(32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0); // min normal kept
    send(32'h80800000, 32'h3F000000, 32'h80000000, 0, 0, 1); // exp 0 -> underflow, neg
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 1, 0, 0); // inf*0
    send(32'h7F800000, 32'hBF800000, 32'hFF800000, 1, 0, 0); // inf*-1
    send(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, 0, 0); // nan
    send(32'h00000000, 32'hC0400000, 32'h80000000, 0, 0, 0); // 0*-3
    send(32'h00000001, 32'h3F800000, 32'h00000000, 0, 0, 0); // subnormal flushed
    send(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0); // sticky only
    send(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 0); // tie, odd -> up
    send(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0, 0, 0); // tie, even -> stay
    send(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 0, 0, 0); // rounding carry
    idle();
    drain();

    // Outputs hold while in_valid=0
    repeat (3) @(negedge CLK);
    check("hold_result", {3'b0, result}, {3'b0, last_res});
    check("hold_out_valid", {34'd0, out_valid}, 35'd0);

    // Mid-stream asynchronous reset
    send(32'h40A00000, 32'h3F800000, 32'h40A00000, 0, 0, 0);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_clear", {out_valid, Exception, Overflow, Underflow, result[30:0]}, 35'd0);
    check("async_reset_msb", {34'd0, result[31]}, 35'd0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset_held_while_valid", {out_valid, Exception, Overflow, Underflow, result[30:0]}, 35'd0);
    in_valid = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("out_valid_low_after_reset", {34'd0, out_valid}, 35'd0);
    end
    send(32'h40A00000, 32'h40A00000, 32'h41C80000, 0, 0, 0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
